cla_mp_add_seq: RTL and testbench



---
 rtl/cla_seq_pkg.sv | 21 ++
 rtl/carry_look_ahead_16_4bit.sv | 50 +++++
 rtl/cla_mp_add_seq.sv | 108 ++++++++++
 tb/tb_cla_mp_add_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared constants, FSM encoding and sizing helper for the multi-precision add sequencer.
package cla_seq_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Limb index width: clog2(words), never narrower than one bit.
  function automatic int idx_width(input int words);
    if (words <= 1) begin
      return 1;
    end else begin
      return $clog2(words);
    end
  endfunction

endpackage

// File: rtl/carry_look_ahead_16_4bit.sv
// 16-bit carry-look-ahead adder built from four 4-bit lookahead groups and a group-level lookahead.
// sum[16] is the carry out.
module carry_look_ahead_16_4bit
  import cla_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W:0]   sum
);

  logic [LIMB_W-1:0] g_s;
  logic [LIMB_W-1:0] p_s;
  logic [LIMB_W-1:0] c_s;
  logic [3:0]        gg_s;
  logic [3:0]        gp_s;
  logic [3:0]        gc_s;
  logic              cout_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    localparam int B = 4 * j;
    assign gg_s[j] = g_s[B+3]
                   | (p_s[B+3] & g_s[B+2])
                   | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                   | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);
    assign gp_s[j] = &p_s[B+3:B];

    // Bit carries inside a group come only from the group carry-in, never from each other.
    assign c_s[B]   = gc_s[j];
    assign c_s[B+1] = g_s[B] | (p_s[B] & gc_s[j]);
    assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B]) | (p_s[B+1] & p_s[B] & gc_s[j]);
    assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1]) | (p_s[B+2] & p_s[B+1] & g_s[B])
                    | (p_s[B+2] & p_s[B+1] & p_s[B] & gc_s[j]);
  end

  assign gc_s[0] = cin;
  assign gc_s[1] = gg_s[0] | (gp_s[0] & cin);
  assign gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
  assign gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                 | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
  assign cout_s  = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                 | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                 | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);

  assign sum = {cout_s, p_s ^ c_s};

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision adder: one 16-bit CLA reused across WORDS limbs, carry held in a register.
// Optional subtract path enabled by defining CLA_SEQ_SUB_EN.
module cla_mp_add_seq
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LIMB_W*WORDS-1:0] in_a,
  input  logic [LIMB_W*WORDS-1:0] in_b,
  input  logic                    in_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                    in_sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*WORDS-1:0] out_sum,
  output logic                    out_cout,
  output logic                    out_ovf
);

  localparam int W     = LIMB_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     a_sh_r;
  logic [W-1:0]     b_sh_r;
  logic [W-1:0]     beff_s;
  logic             cin_eff_s;
  logic [LIMB_W:0]  add_sum_s;
  logic             last_s;

`ifdef CLA_SEQ_SUB_EN
  assign beff_s    = in_sub ? ~in_b : in_b;
  assign cin_eff_s = in_sub ? 1'b1 : in_cin;
`else
  assign beff_s    = in_b;
  assign cin_eff_s = in_cin;
`endif

  // Operands are shifted down each limb, so the adder always sees the low limb.
  carry_look_ahead_16_4bit u_cla (
    .a   (a_sh_r[LIMB_W-1:0]),
    .b   (b_sh_r[LIMB_W-1:0]),
    .cin (carry_r),
    .sum (add_sum_s)
  );

  assign last_s    = (idx_r == IDX_W'(WORDS - 1));
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  // Sequencer state, operand shift registers and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      carry_r  <= 1'b0;
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= in_a;
            b_sh_r  <= beff_s;
            carry_r <= cin_eff_s;
            idx_r   <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          out_sum[idx_r*LIMB_W +: LIMB_W] <= add_sum_s[LIMB_W-1:0];
          carry_r <= add_sum_s[LIMB_W];
          a_sh_r  <= a_sh_r >> LIMB_W;
          b_sh_r  <= b_sh_r >> LIMB_W;
          if (last_s) begin
            // On the top limb the shift-register low bits hold the operand sign bits.
            out_cout <= add_sum_s[LIMB_W];
            out_ovf  <= (a_sh_r[LIMB_W-1] == b_sh_r[LIMB_W-1]) &&
                        (add_sum_s[LIMB_W-1] != a_sh_r[LIMB_W-1]);
            idx_r    <= '0;
            state_r  <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Scoreboard bench for cla_mp_add_seq (WORDS=4 main instance plus a WORDS=1 instance).
module tb_cla_mp_add_seq;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf;
  logic [63:0] in_a, in_b, out_sum;
  logic        in_sub;

  logic        s_valid, s_ready, s_cin, s_out_valid, s_cout, s_ovf;
  logic [15:0] s_a, s_b, s_sum;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];
  exp_t held;

  always #5 clk = ~clk;

  cla_mp_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  cla_mp_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_cin(s_cin),
`ifdef CLA_SEQ_SUB_EN
    .in_sub(1'b0),
`endif
    .out_valid(s_out_valid), .out_ready(1'b1), .out_sum(s_sum),
    .out_cout(s_cout), .out_ovf(s_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [63:0] beff;
    logic        c;
    logic [64:0] full;
    beff = b;
    c    = cin;
`ifdef CLA_SEQ_SUB_EN
    if (sub) begin
      beff = ~b;
      c    = 1'b1;
    end
`endif
    full   = {1'b0, a} + {1'b0, beff} + {64'd0, c};
    e.sum  = full[63:0];
    e.cout = full[64];
    e.ovf  = (a[63] == beff[63]) && (full[63] != a[63]);
    return e;
  endfunction

  // Accept one operand pair, then wait (bounded) for out_valid and score the result.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub);
    int   cyc;
    exp_t e;
    sb_q.push_back(model(a, b, cin, sub));
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      held = e;
      check({tag, "_sum"}, out_sum, e.sum);
      check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, e.cout});
      check({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, e.ovf});
    end else begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", out_sum, 64'd0);
    check("rst_cout_ovf", {62'd0, out_cout, out_ovf}, 64'd0);

    run_op("maxp1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("maxp1_ret_ready", {62'd0, in_ready, out_valid}, 64'd2);

    run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_op("carry_chain", 64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      run_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'b0);
      @(posedge clk); #1;
    end

`ifdef CLA_SEQ_SUB_EN
    run_op("sub_borrow", 64'h10, 64'h20, 1'b0, 1'b1);
    @(posedge clk); #1;
    run_op("sub_noborrow", 64'h20, 64'h10, 1'b0, 1'b1);
    @(posedge clk); #1;
`endif

    // Backpressure: hold the result for 10 cycles while a new request is offered.
    out_ready = 1'b0;
    run_op("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    in_a = 64'h5555; in_b = 64'hAAAA; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_ready", {63'd0, in_ready}, 64'd0);
      check("bp_sum", out_sum, held.sum);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", {62'd0, in_ready, out_valid}, 64'd2);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_no_extra", {63'd0, out_valid}, 64'd0);
    end

    // Reset while limb 2 is being processed aborts the operation.
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h3; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {63'd0, in_ready}, 64'd1);
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    check("abort_sum", out_sum, 64'd0);
    cyc = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) cyc++;
    end
    check("abort_no_result", 64'(cyc), 64'd0);

    // WORDS=1 instance: single-cycle RUN.
    s_a = 16'hFFFF; s_b = 16'h0001; s_cin = 1'b1; s_valid = 1'b1;
    check("w1_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    cyc = 0;
    while (s_out_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w1_latency", 64'(cyc), 64'd1);
    check("w1_sum", {48'd0, s_sum}, 64'h0001);
    check("w1_cout", {63'd0, s_cout}, 64'd1);
    check("w1_ovf", {63'd0, s_ovf}, 64'd0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
